uart_rx_byte: RTL and testbench

8-bit UART receiver front-end, 8 data bits, 1 stop bit, optional parity. It samples the asynchronous rx line and emits one byte per received frame as a single-cycle strobe. It sits directly upstream of the command accumulator: data_out drives input_data and data_valid drives accumulate. Framing and parity errors are flagged and the offending byte is dropped, so the accumulator never sees a corrupted byte.

---
 rtl/uart_rx_byte_pkg.sv | 25 ++
 rtl/uart_rx_sync.sv | 33 +++
 rtl/uart_rx_byte.sv | 151 +++++++++++++++
 tb/tb_uart_rx_byte.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_byte_pkg.sv
// Shared UART definitions: receiver FSM states, parity modes, command terminator bytes.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package uart_pkg;

  // Receiver FSM states
  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_START      = 3'd1,
    ST_DATA       = 3'd2,
    ST_PARITY     = 3'd3,
    ST_STOP       = 3'd4,
    ST_BREAK_WAIT = 3'd5
  } rx_state_e;

  // Parity modes for the PARITY parameter
  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  // Command terminator, shared with the accumulator and the benches
  localparam logic [7:0] TERM_BYTE0 = 8'hBE;
  localparam logic [7:0] TERM_BYTE1 = 8'hEF;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous, idle-high serial line.
// Latency: 2 clk cycles from pin to q.
// Backpressure: none; free-running, resets to the idle (high) level.
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_d, meta_q;
  logic sync_d, sync_q;

  // Next values: shift the line through the two stages
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // Both stages reset to 1 so a reset never looks like a start bit
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx_byte.sv
// UART receiver: 8 data bits, optional parity, 1 stop bit; emits good bytes as a one-cycle strobe.
// Latency: data_valid 1 cycle after the mid-stop-bit sample (pin-low + 2 + CPB/2 + (9+P)*CPB + 1).
// Backpressure: none; downstream must accept each data_valid pulse, errored frames are dropped.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int PARITY       = PARITY_NONE
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       framing_error,
  output logic       parity_error,
  output logic       busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic             rx_s;
  rx_state_e        state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic [3:0]       bit_idx_d, bit_idx_q;
  logic [7:0]       shift_d, shift_q;
  logic             parity_bad_d, parity_bad_q;
  logic [7:0]       data_d, data_q;
  logic             data_valid_d, data_valid_q;
  logic             framing_error_d, framing_error_q;
  logic             parity_error_d, parity_error_q;

  uart_rx_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  // Frame FSM: counts baud ticks, samples mid-bit, and decides the outcome at the stop bit
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q + CNT_W'(1);
    bit_idx_d       = bit_idx_q;
    shift_d         = shift_q;
    parity_bad_d    = parity_bad_q;
    data_d          = data_q;
    data_valid_d    = 1'b0;
    framing_error_d = 1'b0;
    parity_error_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = ST_START;
      end
      ST_START: begin
        // Re-check at mid start bit so a short glitch is rejected silently
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d      = ST_DATA;
            bit_idx_d    = 4'd0;
            parity_bad_d = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DATA: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d = '0;
          shift_d[bit_idx_q[2:0]] = rx_s;
          if (bit_idx_q == 4'd7) begin
            state_d = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 4'd1;
          end
        end
      end
      ST_PARITY: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d   = '0;
          state_d = ST_STOP;
          if (PARITY == PARITY_EVEN) parity_bad_d = ((^shift_q) != rx_s);
          else                       parity_bad_d = ((^shift_q) == rx_s);
        end
      end
      ST_STOP: begin
        // Framing wins over parity; only one outcome strobe per frame
        if (cnt_q == FULL_LAST) begin
          cnt_d = '0;
          if (!rx_s) begin
            framing_error_d = 1'b1;
            state_d         = ST_BREAK_WAIT;
          end else if (parity_bad_q) begin
            parity_error_d = 1'b1;
            state_d        = ST_IDLE;
          end else begin
            data_d       = shift_q;
            data_valid_d = 1'b1;
            state_d      = ST_IDLE;
          end
        end
      end
      ST_BREAK_WAIT: begin
        // Hold off until the line is released so a break cannot start new frames
        cnt_d = '0;
        if (rx_s) state_d = ST_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any frame in flight without a strobe
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      cnt_q           <= '0;
      bit_idx_q       <= 4'd0;
      shift_q         <= 8'h00;
      parity_bad_q    <= 1'b0;
      data_q          <= 8'h00;
      data_valid_q    <= 1'b0;
      framing_error_q <= 1'b0;
      parity_error_q  <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      bit_idx_q       <= bit_idx_d;
      shift_q         <= shift_d;
      parity_bad_q    <= parity_bad_d;
      data_q          <= data_d;
      data_valid_q    <= data_valid_d;
      framing_error_q <= framing_error_d;
      parity_error_q  <= parity_error_d;
    end
  end

  assign data_out      = data_q;
  assign data_valid    = data_valid_q;
  assign framing_error = framing_error_q;
  assign parity_error  = parity_error_q;
  assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed bench for uart_rx_byte: one instance without parity, one with even parity.
module tb_uart_rx_byte;
  import uart_pkg::*;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx0 = 1'b1;
  logic       rx1 = 1'b1;
  logic [7:0] data_out0, data_out1;
  logic       dv0, dv1, fe0, fe1, pe0, pe1, busy0, busy1;

  int vec_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;

  logic [7:0] dv_byte0[$];
  int         dv_cyc0[$];
  logic       dv_busy0[$];
  int         fe_cyc0[$];
  logic       fe_busy0[$];
  int         pe_cnt0 = 0;
  logic [7:0] dv_byte1[$];
  int         dv_cyc1[$];
  int         fe_cnt1 = 0;
  int         pe_cyc1[$];
  logic [7:0] pe_data1[$];
  logic       pe_busy1[$];
  int         multi_cnt = 0;

  uart_rx_byte #(.CLKS_PER_BIT(CPB), .PARITY(PARITY_NONE)) dut0 (
    .clk(clk), .reset(reset), .rx(rx0), .data_out(data_out0), .data_valid(dv0),
    .framing_error(fe0), .parity_error(pe0), .busy(busy0)
  );

  uart_rx_byte #(.CLKS_PER_BIT(CPB), .PARITY(PARITY_EVEN)) dut1 (
    .clk(clk), .reset(reset), .rx(rx1), .data_out(data_out1), .data_valid(dv1),
    .framing_error(fe1), .parity_error(pe1), .busy(busy1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every strobe with its cycle number, away from the active edge
  always @(negedge clk) begin
    if (!reset) begin
      if (dv0) begin dv_byte0.push_back(data_out0); dv_cyc0.push_back(cyc); dv_busy0.push_back(busy0); end
      if (fe0) begin fe_cyc0.push_back(cyc); fe_busy0.push_back(busy0); end
      if (pe0) pe_cnt0++;
      if (dv1) begin dv_byte1.push_back(data_out1); dv_cyc1.push_back(cyc); end
      if (fe1) fe_cnt1++;
      if (pe1) begin pe_cyc1.push_back(cyc); pe_data1.push_back(data_out1); pe_busy1.push_back(busy1); end
      if ((int'(dv0) + int'(fe0) + int'(pe0) > 1) || (int'(dv1) + int'(fe1) + int'(pe1) > 1)) multi_cnt++;
    end
  end

  // Hold a line level for n cycles; called and returns on a negedge
  task automatic drive(input int which, input logic v, input int n);
    if (which == 0) rx0 = v; else rx1 = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input int which, input logic [7:0] b, input logic has_par,
                            input logic par_bit, input logic stop_bit);
    drive(which, 1'b0, CPB);
    for (int i = 0; i < 8; i++) drive(which, b[i], CPB);
    if (has_par) drive(which, par_bit, CPB);
    drive(which, stop_bit, CPB);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    vec_cnt++; if (data_out0 !== 8'h00) begin err_cnt++; $display("FAIL reset_data_out got=%h exp=00", data_out0); end
    vec_cnt++; if ({dv0, fe0, pe0, busy0} !== 4'b0000) begin err_cnt++; $display("FAIL reset_flags got=%b exp=0000", {dv0, fe0, pe0, busy0}); end
    vec_cnt++; if ({dv1, fe1, pe1, busy1} !== 4'b0000) begin err_cnt++; $display("FAIL reset_flags_par got=%b exp=0000", {dv1, fe1, pe1, busy1}); end
  endtask

  // 0xA5: strobe exactly 155 cycles after the pin first goes low
  task automatic test_single_byte();
    int n, nf, np, t0;
    logic [7:0] b;
    b = 8'hA5;
    n = dv_byte0.size(); nf = fe_cyc0.size(); np = pe_cnt0; t0 = cyc;
    drive(0, 1'b0, 4);
    vec_cnt++; if (busy0 !== 1'b1) begin err_cnt++; $display("FAIL single_busy_start got=%b exp=1", busy0); end
    drive(0, 1'b0, CPB - 4);
    for (int i = 0; i < 8; i++) drive(0, b[i], CPB);
    drive(0, 1'b1, CPB + 20);
    vec_cnt++; if (dv_byte0.size() - n !== 1) begin err_cnt++; $display("FAIL single_dv_count got=%0d exp=1", dv_byte0.size() - n); end
    vec_cnt++; if (dv_byte0[n] !== 8'hA5) begin err_cnt++; $display("FAIL single_data got=%h exp=a5", dv_byte0[n]); end
    vec_cnt++; if (dv_cyc0[n] - t0 !== 155) begin err_cnt++; $display("FAIL single_latency got=%0d exp=155", dv_cyc0[n] - t0); end
    vec_cnt++; if (dv_busy0[n] !== 1'b0) begin err_cnt++; $display("FAIL single_busy_at_dv got=%b exp=0", dv_busy0[n]); end
    vec_cnt++; if ((fe_cyc0.size() - nf) + (pe_cnt0 - np) !== 0) begin err_cnt++; $display("FAIL single_errors got=%0d exp=0", (fe_cyc0.size() - nf) + (pe_cnt0 - np)); end
  endtask

  task automatic test_back_to_back();
    int n, t0;
    logic [7:0] exp_b [3];
    exp_b[0] = 8'h31; exp_b[1] = TERM_BYTE0; exp_b[2] = TERM_BYTE1;
    n = dv_byte0.size(); t0 = cyc;
    for (int k = 0; k < 3; k++) send_frame(0, exp_b[k], 1'b0, 1'b0, 1'b1);
    drive(0, 1'b1, 20);
    vec_cnt++; if (dv_byte0.size() - n !== 3) begin err_cnt++; $display("FAIL b2b_dv_count got=%0d exp=3", dv_byte0.size() - n); end
    for (int k = 0; k < 3; k++) begin
      vec_cnt++; if (dv_byte0[n+k] !== exp_b[k]) begin err_cnt++; $display("FAIL b2b_data%0d got=%h exp=%h", k, dv_byte0[n+k], exp_b[k]); end
      vec_cnt++; if (dv_cyc0[n+k] - t0 !== 155 + 160*k) begin err_cnt++; $display("FAIL b2b_time%0d got=%0d exp=%0d", k, dv_cyc0[n+k] - t0, 155 + 160*k); end
    end
  endtask

  // Four low cycles: START re-samples high at its midpoint and returns to IDLE at T+11
  task automatic test_glitch();
    int n, nf, np;
    n = dv_byte0.size(); nf = fe_cyc0.size(); np = pe_cnt0;
    drive(0, 1'b0, 4);
    vec_cnt++; if (busy0 !== 1'b1) begin err_cnt++; $display("FAIL glitch_busy_rise got=%b exp=1", busy0); end
    drive(0, 1'b1, 7);
    vec_cnt++; if (busy0 !== 1'b0) begin err_cnt++; $display("FAIL glitch_busy_fall got=%b exp=0", busy0); end
    drive(0, 1'b1, 40);
    vec_cnt++; if ((dv_byte0.size() - n) + (fe_cyc0.size() - nf) + (pe_cnt0 - np) !== 0) begin err_cnt++; $display("FAIL glitch_pulses got=%0d exp=0", (dv_byte0.size() - n) + (fe_cyc0.size() - nf) + (pe_cnt0 - np)); end
  endtask

  task automatic test_framing_break();
    int n, nf, t0;
    n = dv_byte0.size(); nf = fe_cyc0.size(); t0 = cyc;
    send_frame(0, 8'h55, 1'b0, 1'b0, 1'b0);
    drive(0, 1'b0, 100 * CPB);
    vec_cnt++; if (busy0 !== 1'b1) begin err_cnt++; $display("FAIL break_busy got=%b exp=1", busy0); end
    vec_cnt++; if (fe_cyc0.size() - nf !== 1) begin err_cnt++; $display("FAIL break_fe_count got=%0d exp=1", fe_cyc0.size() - nf); end
    vec_cnt++; if (fe_cyc0[nf] - t0 !== 155) begin err_cnt++; $display("FAIL break_fe_time got=%0d exp=155", fe_cyc0[nf] - t0); end
    vec_cnt++; if (fe_busy0[nf] !== 1'b1) begin err_cnt++; $display("FAIL break_busy_at_fe got=%b exp=1", fe_busy0[nf]); end
    vec_cnt++; if (dv_byte0.size() - n !== 0) begin err_cnt++; $display("FAIL break_dv_count got=%0d exp=0", dv_byte0.size() - n); end
    drive(0, 1'b1, 5);
    vec_cnt++; if (busy0 !== 1'b0) begin err_cnt++; $display("FAIL break_release got=%b exp=0", busy0); end
    send_frame(0, 8'h12, 1'b0, 1'b0, 1'b1);
    drive(0, 1'b1, 20);
    vec_cnt++; if (dv_byte0.size() - n !== 1) begin err_cnt++; $display("FAIL break_next_count got=%0d exp=1", dv_byte0.size() - n); end
    vec_cnt++; if (dv_byte0[n] !== 8'h12) begin err_cnt++; $display("FAIL break_next_data got=%h exp=12", dv_byte0[n]); end
  endtask

  // Even parity: 0x07 has three ones, so parity bit 1 is good and 0 is bad
  task automatic test_parity();
    int n, np, nf, t0, t1;
    n = dv_byte1.size(); np = pe_cyc1.size(); nf = fe_cnt1; t0 = cyc;
    send_frame(1, 8'h07, 1'b1, 1'b1, 1'b1);
    drive(1, 1'b1, 20);
    t1 = cyc;
    send_frame(1, 8'h07, 1'b1, 1'b0, 1'b1);
    drive(1, 1'b1, 20);
    vec_cnt++; if (dv_byte1.size() - n !== 1) begin err_cnt++; $display("FAIL par_dv_count got=%0d exp=1", dv_byte1.size() - n); end
    vec_cnt++; if (dv_byte1[n] !== 8'h07) begin err_cnt++; $display("FAIL par_data got=%h exp=07", dv_byte1[n]); end
    vec_cnt++; if (dv_cyc1[n] - t0 !== 171) begin err_cnt++; $display("FAIL par_latency got=%0d exp=171", dv_cyc1[n] - t0); end
    vec_cnt++; if (pe_cyc1.size() - np !== 1) begin err_cnt++; $display("FAIL par_pe_count got=%0d exp=1", pe_cyc1.size() - np); end
    vec_cnt++; if (pe_cyc1[np] - t1 !== 171) begin err_cnt++; $display("FAIL par_pe_time got=%0d exp=171", pe_cyc1[np] - t1); end
    vec_cnt++; if (pe_data1[np] !== 8'h07) begin err_cnt++; $display("FAIL par_data_held got=%h exp=07", pe_data1[np]); end
    vec_cnt++; if (pe_busy1[np] !== 1'b0) begin err_cnt++; $display("FAIL par_busy_at_pe got=%b exp=0", pe_busy1[np]); end
    vec_cnt++; if (fe_cnt1 - nf !== 0) begin err_cnt++; $display("FAIL par_fe_count got=%0d exp=0", fe_cnt1 - nf); end
  endtask

  // Reset mid bit 4 of 0xF5 (bits 4..7 high, so the tail cannot look like a start bit)
  task automatic test_reset_midframe();
    int n, nf, np;
    logic [7:0] b;
    b = 8'hF5;
    vec_cnt++; if (data_out0 !== 8'h12) begin err_cnt++; $display("FAIL rst_pre_data got=%h exp=12", data_out0); end
    n = dv_byte0.size(); nf = fe_cyc0.size(); np = pe_cnt0;
    drive(0, 1'b0, CPB);
    for (int i = 0; i < 4; i++) drive(0, b[i], CPB);
    drive(0, b[4], 8);
    reset = 1'b1;
    @(negedge clk);
    vec_cnt++; if (data_out0 !== 8'h00) begin err_cnt++; $display("FAIL rst_mid_data got=%h exp=00", data_out0); end
    vec_cnt++; if ({dv0, fe0, pe0, busy0} !== 4'b0000) begin err_cnt++; $display("FAIL rst_mid_flags got=%b exp=0000", {dv0, fe0, pe0, busy0}); end
    reset = 1'b0;
    drive(0, 1'b1, 7 + 3*CPB + CPB + 40);
    vec_cnt++; if ((dv_byte0.size() - n) + (fe_cyc0.size() - nf) + (pe_cnt0 - np) !== 0) begin err_cnt++; $display("FAIL rst_mid_pulses got=%0d exp=0", (dv_byte0.size() - n) + (fe_cyc0.size() - nf) + (pe_cnt0 - np)); end
    send_frame(0, 8'hC3, 1'b0, 1'b0, 1'b1);
    drive(0, 1'b1, 20);
    vec_cnt++; if (dv_byte0.size() - n !== 1) begin err_cnt++; $display("FAIL rst_next_count got=%0d exp=1", dv_byte0.size() - n); end
    vec_cnt++; if (dv_byte0[n] !== 8'hC3) begin err_cnt++; $display("FAIL rst_next_data got=%h exp=c3", dv_byte0[n]); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_glitch();
    test_framing_break();
    test_parity();
    test_reset_midframe();
    vec_cnt++; if (multi_cnt !== 0) begin err_cnt++; $display("FAIL strobe_exclusive got=%0d exp=0", multi_cnt); end
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
